// File: rtl/dmem_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | dmem_pkg : width codes, FSM states and lane helpers for data_mem_ctrl    |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
package dmem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_SPLIT = 1'b1
  } dmem_state_e;

  function automatic logic [3:0] byte_mask(input logic [2:0] f3);
    case (f3[1:0])
      2'b00:   byte_mask = 4'b0001;
      2'b01:   byte_mask = 4'b0011;
      default: byte_mask = 4'b1111;
    endcase
  endfunction

  // Unsigned widths exist only for loads.
  function automatic logic f3_legal(input logic [2:0] f3, input logic we);
    case (f3)
      F3_B, F3_H, F3_W: f3_legal = 1'b1;
      F3_BU, F3_HU:     f3_legal = ~we;
      default:          f3_legal = 1'b0;
    endcase
  endfunction

  function automatic logic is_aligned(input logic [2:0] f3, input logic [1:0] off);
    case (f3[1:0])
      2'b00:   is_aligned = 1'b1;
      2'b01:   is_aligned = ~off[0];
      default: is_aligned = (off == 2'b00);
    endcase
  endfunction

  function automatic logic [31:0] extend(input logic [2:0] f3, input logic [31:0] d);
    case (f3)
      F3_B:    extend = {{24{d[7]}}, d[7:0]};
      F3_H:    extend = {{16{d[15]}}, d[15:0]};
      F3_BU:   extend = {24'h0, d[7:0]};
      F3_HU:   extend = {16'h0, d[15:0]};
      default: extend = d;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/dmem_bank.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | dmem_bank : 32-bit word store, per-byte write enables, synchronous read  |
// | Revision  : 1.0                                                          |
// +--------------------------------------------------------------------------+
module dmem_bank #(
  parameter int WORD_AW = 14
) (
  input  logic               clk,
  input  logic               we_i,
  input  logic [3:0]         be_i,
  input  logic [WORD_AW-1:0] waddr_i,
  input  logic [31:0]        wdata_i,
  input  logic [WORD_AW-1:0] raddr_i,
  output logic [31:0]        rdata_o
);

  logic [31:0] mem_q [2**WORD_AW];
  logic [31:0] rdata_q;

  always_ff @(posedge clk) begin
    for (int b = 0; b < 4; b++) begin
      if (we_i && be_i[b]) begin
        mem_q[waddr_i][8*b +: 8] <= wdata_i[8*b +: 8];
      end
    end
    rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule
`default_nettype wire

// File: rtl/data_mem_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | data_mem_ctrl : RISC-V load/store unit over a byte-enabled word bank.    |
// | Optional MISALIGNED_SPLIT_EN splits misaligned half/word over 2 words.   |
// | Revision      : 1.0                                                      |
// +--------------------------------------------------------------------------+
module data_mem_ctrl
  import dmem_pkg::*;
#(
  parameter int ADDRESS_WIDTH = 16,
  parameter int DATA_WIDTH    = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic                     req_we,
  input  logic [2:0]               funct3,
  input  logic [ADDRESS_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0]    WriteData,
  output logic [DATA_WIDTH-1:0]    ReadData,
  output logic                     rdata_valid,
  output logic                     access_err
);

  localparam int WAW = ADDRESS_WIDTH - 2;

  if (DATA_WIDTH != 32) begin : g_bad_width
    $error("data_mem_ctrl: DATA_WIDTH must be 32");
  end

  dmem_state_e    state_q, state_d;
  logic           rvalid_q, err_q, split_ld_q, sp_we_q;
  logic [2:0]     f3_q;
  logic [1:0]     off_q;
  logic [31:0]    lo_q, hold_q, sp_data_q;
  logic [3:0]     sp_be_q;
  logic [WAW-1:0] sp_word_q;

  logic           w_accept, w_legal, w_aligned, w_split, w_mis_err, w_ok;
  logic [1:0]     w_off;
  logic [WAW-1:0] w_word;
  logic [7:0]     w_be64;
  logic [63:0]    w_wd64, w_m64;
  logic [31:0]    w_lo, w_ext, w_rdata;
  logic           w_bank_we;
  logic [3:0]     w_bank_be;
  logic [WAW-1:0] w_bank_waddr, w_bank_raddr;
  logic [31:0]    w_bank_wdata;

  assign req_ready = (state_q == ST_IDLE);
  assign w_accept  = req_valid & req_ready & ~rst;
  assign w_off     = addr[1:0];
  assign w_word    = addr[ADDRESS_WIDTH-1:2];
  assign w_legal   = f3_legal(funct3, req_we);
  assign w_aligned = is_aligned(funct3, w_off);

`ifdef MISALIGNED_SPLIT_EN
  assign w_split   = w_legal & ~w_aligned;
  assign w_mis_err = 1'b0;
`else
  assign w_split   = 1'b0;
  assign w_mis_err = w_legal & ~w_aligned;
`endif

  assign w_ok = w_legal & ~w_mis_err;

  // Steer store data/enables across a 64-bit window spanning word and word+1.
  assign w_be64 = {4'b0000, byte_mask(funct3)} << w_off;
  assign w_wd64 = {32'h0, WriteData} << {w_off, 3'b000};

  always_comb begin
    state_d      = state_q;
    w_bank_we    = 1'b0;
    w_bank_be    = w_be64[3:0];
    w_bank_waddr = w_word;
    w_bank_wdata = w_wd64[31:0];
    w_bank_raddr = w_word;
    case (state_q)
      ST_IDLE: begin
        if (w_accept && w_ok) begin
          w_bank_we = req_we;
          if (w_split) state_d = ST_SPLIT;
        end
      end
      ST_SPLIT: begin
        state_d      = ST_IDLE;
        w_bank_we    = sp_we_q & ~rst;
        w_bank_be    = sp_be_q;
        w_bank_waddr = sp_word_q;
        w_bank_wdata = sp_data_q;
        w_bank_raddr = sp_word_q;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rvalid_q   <= 1'b0;
      err_q      <= 1'b0;
      split_ld_q <= 1'b0;
      hold_q     <= 32'h0;
    end else begin
      rvalid_q <= 1'b0;
      err_q    <= 1'b0;
      if (rvalid_q) hold_q <= w_ext;
      if (w_accept) begin
        err_q      <= ~w_ok;
        rvalid_q   <= w_ok & ~req_we & ~w_split;
        split_ld_q <= w_split & ~req_we;
        f3_q       <= funct3;
        off_q      <= w_off;
        sp_word_q  <= w_word + WAW'(1);
        sp_data_q  <= w_wd64[63:32];
        sp_be_q    <= w_be64[7:4];
        sp_we_q    <= req_we;
      end
      if (state_q == ST_SPLIT) begin
        lo_q     <= w_rdata;
        rvalid_q <= ~sp_we_q;
      end
    end
  end

  dmem_bank #(
    .WORD_AW (WAW)
  ) u_bank (
    .clk     (clk),
    .we_i    (w_bank_we),
    .be_i    (w_bank_be),
    .waddr_i (w_bank_waddr),
    .wdata_i (w_bank_wdata),
    .raddr_i (w_bank_raddr),
    .rdata_o (w_rdata)
  );

  // Split loads merge the saved first word with the second word now on the bank port.
  assign w_lo  = split_ld_q ? lo_q : w_rdata;
  assign w_m64 = {w_rdata, w_lo} >> {off_q, 3'b000};
  assign w_ext = extend(f3_q, w_m64[31:0]);

  assign ReadData    = rvalid_q ? w_ext : hold_q;
  assign rdata_valid = rvalid_q;
  assign access_err  = err_q;

endmodule
`default_nettype wire

// File: tb/tb_data_mem_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_data_mem_ctrl : randomized self-checking bench with byte-array model  |
// | Revision         : 1.0                                                   |
// +--------------------------------------------------------------------------+
module tb_data_mem_ctrl;

`ifdef MISALIGNED_SPLIT_EN
  localparam bit SPLIT_EN = 1'b1;
`else
  localparam bit SPLIT_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [2:0]  funct3 = 3'b000;
  logic [15:0] addr = 16'h0;
  logic [31:0] WriteData = 32'h0;
  logic [31:0] ReadData;
  logic        rdata_valid;
  logic        access_err;

  int n_tests = 0;
  int n_fail  = 0;
  logic [7:0]  ref_mem [0:65535];
  logic [31:0] last_rd = 32'h0;

  always #5 clk = ~clk;

  data_mem_ctrl #(
    .ADDRESS_WIDTH (16),
    .DATA_WIDTH    (32)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_we      (req_we),
    .funct3      (funct3),
    .addr        (addr),
    .WriteData   (WriteData),
    .ReadData    (ReadData),
    .rdata_valid (rdata_valid),
    .access_err  (access_err)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  function automatic int size_of(input logic [2:0] f3);
    return (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
  endfunction

  function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [15:0] a);
    logic [31:0] v;
    int sz;
    v  = 32'h0;
    sz = size_of(f3);
    for (int i = 0; i < sz; i++) v[8*i +: 8] = ref_mem[16'(a + 16'(i))];
    if (!f3[2] && sz < 4 && v[8*sz-1])
      for (int i = sz * 8; i < 32; i++) v[i] = 1'b1;
    return v;
  endfunction

  task automatic model_store(input logic [2:0] f3, input logic [15:0] a, input logic [31:0] wd);
    for (int i = 0; i < size_of(f3); i++) ref_mem[16'(a + 16'(i))] = wd[8*i +: 8];
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    rst       = 1'b0;
    req_valid = 1'b0;
    last_rd   = 32'h0;
    check("rst_status", {29'h0, req_ready, rdata_valid, access_err}, 32'h4);
    check("rst_rdata", ReadData, 32'h0);
  endtask

  // One access, observed over N+1 and N+2; rd returns the load result.
  task automatic do_op(input logic we, input logic [2:0] f3, input logic [15:0] a,
                       input logic [31:0] wd, output logic [31:0] rd);
    bit legal, al, spl, err, rv1, rv2;
    logic [31:0] exp;
    legal = (f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2) || ((f3 == 3'd4 || f3 == 3'd5) && !we);
    al    = (int'(a) % size_of(f3)) == 0;
    spl   = legal && !al && SPLIT_EN;
    err   = !legal || (!al && !SPLIT_EN);
    rv1   = !err && !we && !spl;
    rv2   = !err && !we && spl;
    exp   = (!err && !we) ? model_load(f3, a) : last_rd;
    if (!err && we) model_store(f3, a, wd);

    check("ready_N", {31'h0, req_ready}, 32'h1);
    req_valid = 1'b1; req_we = we; funct3 = f3; addr = a; WriteData = wd;
    @(posedge clk); #1;
    req_valid = 1'b0;
    check("status_N1", {29'h0, req_ready, rdata_valid, access_err}, {29'h0, !spl, rv1, err});
    check("rdata_N1", ReadData, rv1 ? exp : last_rd);
    if (rv1) last_rd = exp;
    @(posedge clk); #1;
    check("status_N2", {29'h0, req_ready, rdata_valid, access_err}, {29'h0, 1'b1, rv2, 1'b0});
    check("rdata_N2", ReadData, rv2 ? exp : last_rd);
    if (rv2) last_rd = exp;
    rd = last_rd;
  endtask

  logic [31:0] rd, wd;
  logic        we;
  logic [2:0]  f3;
  logic [15:0] a;

  initial begin
    do_reset();

    // Known contents in the random address window (low region and top words).
    for (int w = 0; w < 68; w++) do_op(1'b1, 3'd2, 16'(w * 4), $urandom, rd);
    for (int w = 0; w < 4; w++)  do_op(1'b1, 3'd2, 16'hFFF0 + 16'(w * 4), $urandom, rd);

    do_op(1'b1, 3'd2, 16'h0010, 32'hDEADBEEF, rd);
    do_op(1'b0, 3'd2, 16'h0010, 32'h0, rd);
    check("lw_10", rd, 32'hDEADBEEF);
    do_op(1'b1, 3'd0, 16'h0013, 32'h00000080, rd);
    do_op(1'b0, 3'd0, 16'h0013, 32'h0, rd);
    check("lb_13", rd, 32'hFFFFFF80);
    do_op(1'b0, 3'd4, 16'h0013, 32'h0, rd);
    check("lbu_13", rd, 32'h00000080);
    do_op(1'b0, 3'd2, 16'h0010, 32'h0, rd);
    check("lw_10b", rd, 32'h80ADBEEF);
    do_op(1'b1, 3'd1, 16'h0022, 32'h00001234, rd);
    do_op(1'b1, 3'd3, 16'h0020, 32'hFFFFFFFF, rd);
    do_op(1'b0, 3'd1, 16'h0022, 32'h0, rd);
    check("lh_22", rd, 32'h00001234);

    if (SPLIT_EN) begin
      do_op(1'b1, 3'd2, 16'h0031, 32'hAABBCCDD, rd);
      do_op(1'b0, 3'd2, 16'h0031, 32'h0, rd);
      check("lw_31", rd, 32'hAABBCCDD);
      do_op(1'b0, 3'd4, 16'h0034, 32'h0, rd);
      check("lbu_34", rd, 32'h000000AA);
      // Reset lands in the SPLIT cycle: only the first word's bytes stick.
      check("ready_pre", {31'h0, req_ready}, 32'h1);
      req_valid = 1'b1; req_we = 1'b1; funct3 = 3'd2; addr = 16'h003E; WriteData = 32'h11223344;
      @(posedge clk); #1;
      req_valid = 1'b0;
      check("split_ready", {31'h0, req_ready}, 32'h0);
      ref_mem[16'h003E] = 8'h44;
      ref_mem[16'h003F] = 8'h33;
      do_reset();
      do_op(1'b0, 3'd5, 16'h003E, 32'h0, rd);
      check("lhu_3e", rd, 32'h00003344);
      do_op(1'b0, 3'd5, 16'h0040, 32'h0, rd);
    end else begin
      do_op(1'b0, 3'd2, 16'h0031, 32'h0, rd);
      do_op(1'b1, 3'd2, 16'h0031, 32'hAABBCCDD, rd);
      do_op(1'b0, 3'd2, 16'h0030, 32'h0, rd);
      do_op(1'b1, 3'd2, 16'h003E, 32'h11223344, rd);
      do_op(1'b0, 3'd2, 16'h003C, 32'h0, rd);
    end

    // Request coinciding with reset is dropped.
    req_valid = 1'b1; req_we = 1'b1; funct3 = 3'd2; addr = 16'h0040; WriteData = 32'h5A5A5A5A;
    do_reset();
    do_op(1'b0, 3'd2, 16'h0040, 32'h0, rd);

    // Back-to-back store then load of the same word.
    req_valid = 1'b1; req_we = 1'b1; funct3 = 3'd2; addr = 16'h0048; WriteData = 32'hCAFEF00D;
    @(posedge clk); #1;
    req_we = 1'b0;
    @(posedge clk); #1;
    req_valid = 1'b0;
    model_store(3'd2, 16'h0048, 32'hCAFEF00D);
    check("b2b_valid", {31'h0, rdata_valid}, 32'h1);
    check("b2b_data", ReadData, 32'hCAFEF00D);
    last_rd = 32'hCAFEF00D;
    @(posedge clk); #1;

    for (int k = 0; k < 400; k++) begin
      we = 1'($urandom_range(0, 1));
      f3 = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 7) == 0) a = 16'hFFF8 + 16'($urandom_range(0, 7));
      else                           a = 16'($urandom_range(0, 255));
      wd = $urandom;
      do_op(we, f3, a, wd, rd);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/data_mem_ctrl.md
DATA_MEM_CTRL -- requirements
Module: data_mem_ctrl

Interface
REQ-001 SHALL have parameter ADDRESS_WIDTH, default 16: byte-address width; storage is 2**(ADDRESS_WIDTH-2) 32-bit words.
REQ-002 SHALL have parameter DATA_WIDTH, default 32: port data width; only 32 is supported, and any other value SHALL be rejected at elaboration.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on posedge.
REQ-004 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 SHALL have port req_valid, input, 1 bit: access request this cycle.
REQ-006 SHALL have port req_ready, output, 1 bit: the request is accepted when req_valid and req_ready are both high.
REQ-007 SHALL have port req_we, input, 1 bit: 1 = store, 0 = load.
REQ-008 SHALL have port funct3, input, 3 bits: RISC-V width code; 000 LB/SB, 001 LH/SH, 010 LW/SW, 100 LBU, 101 LHU.
REQ-009 SHALL have port addr, input, ADDRESS_WIDTH bits: byte address (ALU result).
REQ-010 SHALL have port WriteData, input, DATA_WIDTH bits: store data, LSB-aligned.
REQ-011 SHALL have port ReadData, output, DATA_WIDTH bits: extended load result.
REQ-012 SHALL have port rdata_valid, output, 1 bit: ReadData valid, one-cycle pulse.
REQ-013 SHALL have port access_err, output, 1 bit: one-cycle pulse for an illegal funct3 or an unsupported misaligned access.

Function
REQ-014 Storage SHALL be little-endian, word-indexed by addr[ADDRESS_WIDTH-1:2], with per-byte write enables.
REQ-015 Aligned access (byte any; half addr[0]=0; word addr[1:0]=0) accepted in cycle N: a store SHALL commit at the end of N; a load SHALL assert rdata_valid with ReadData in N+1.
REQ-016 Loads SHALL sign-extend for LB/LH and zero-extend for LBU/LHU; stores SHALL write only the addressed bytes, using WriteData[7:0] for SB and WriteData[15:0] for SH.
REQ-017 A store SHALL never assert rdata_valid.
REQ-018 Illegal funct3 (011, 110, 111, or 1xx with req_we=1) SHALL cause no write and assert access_err in N+1, with rdata_valid low.
REQ-019 The FSM states SHALL be IDLE and SPLIT. IDLE to SPLIT happens only on an accepted split access (see REQ-025). SPLIT always returns to IDLE after one cycle.
REQ-020 req_ready SHALL be 1 in IDLE and 0 in SPLIT.
REQ-021 Word-address wrap: an access touching the top word plus the next word SHALL wrap to word 0.
REQ-022 A load in N+1 to the word stored in N SHALL observe the new data (write-before-read at the boundary).
REQ-023 ReadData SHALL hold its last value when rdata_valid is low.

Reset
REQ-024 On rst high at a posedge, the block SHALL set state=IDLE, req_ready=1, rdata_valid=0, access_err=0 and ReadData=0. Memory contents SHALL NOT be cleared.
REQ-024a A request presented in the same cycle as rst SHALL be ignored.
REQ-024b Reset during SPLIT SHALL abandon the second half: the first-half write persists, no rdata_valid is produced, and no error is raised.

Configuration
REQ-025 With macro MISALIGNED_SPLIT_EN defined, a misaligned half or word access SHALL be split as follows.
- The first word is handled in cycle N and the next word in N+1 (SPLIT).
- A store commits its bytes across both words, at the end of N and at the end of N+1.
- A load merges both words and asserts rdata_valid in N+2.
REQ-026 Without MISALIGNED_SPLIT_EN, a misaligned half or word access SHALL perform no write and assert access_err in N+1; the SPLIT state SHALL be unreachable and req_ready SHALL stay at 1.

Structure
REQ-027 The funct3 width-code constants, the FSM state enum, and the byte-enable/extension helper functions SHALL reside in the shared package dmem_pkg.
REQ-028 Storage SHALL be the sub-module dmem_bank: a 32-bit word array with 4-bit byte-enable write and synchronous read.
REQ-029 Lane steering and sign/zero extension SHALL stay in data_mem_ctrl.

Verification
REQ-030 Scenario: SW 0xDEADBEEF @0x10, then LW @0x10 -> rdata_valid one cycle later with ReadData=0xDEADBEEF.
REQ-031 Scenario: SB 0x80 @0x13, then LB @0x13 -> 0xFFFFFF80; LBU @0x13 -> 0x00000080; LW @0x10 -> 0x80ADBEEF.
REQ-032 Scenario: SH 0x1234 @0x22, then LH @0x22 -> 0x00001234; a store with funct3=011 -> access_err pulse and memory unchanged.
REQ-033 Scenario (MISALIGNED_SPLIT_EN): SW 0xAABBCCDD @0x31 -> req_ready low for 1 cycle; LW @0x31 -> rdata_valid at N+2 with ReadData=0xAABBCCDD; LBU @0x34 -> 0xAA.
REQ-034 Scenario (no macro): LW @0x31 -> access_err at N+1, no rdata_valid; SW @0x31 -> memory unchanged.
REQ-035 Scenario: rst asserted in the SPLIT cycle of SW @0x3E -> bytes 0x3E-0x3F written, bytes 0x40-0x41 unchanged, req_ready=1 and rdata_valid=0 after reset.
